fetch_sequencer: RTL

Instruction fetch and sequencing controller for the 8-bit-address / 16-bit-instruction processor. It owns the program counter, drives the address of the combinational program memory, and registers each instruction word. JMP and STOP are resolved locally; every other instruction goes to the execute stage over a valid/ready handshake. It sits between the program memory and the decode/execute datapath.

---
 rtl/fetch_sequencer_pkg.sv | 50 +++++
 rtl/fetch_decode.sv | 33 +++
 rtl/fetch_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared control definitions for the fetch/sequencing block:
//   - instruction field widths and bit positions
//   - control opcode encodings (JMP and STOP are the only ones the sequencer
//     interprets; the others are listed so the whole team uses one table)
//   - FSM state encodings of fetch_sequencer
//   - the classification record produced by fetch_decode
// Optional feature macro: SEQ_STEP_EN (adds the PAUSE state encoding).
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 5;

    // Instruction word layout: [15:11] opcode, [10:8] register, [7:0] addr/imm
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Control opcodes. Anything that is not JMP or STOP is forwarded to execute.
    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 5'h00,
        OP_LDS  = 5'h01,
        OP_STS  = 5'h02,
        OP_ADD  = 5'h03,
        OP_SUB  = 5'h04,
        OP_JMP  = 5'h10,
        OP_STOP = 5'h1F
    } opcode_e;

    // FSM state encodings (kept as plain constants for legacy compatibility)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
`ifdef SEQ_STEP_EN
    localparam logic [2:0] ST_PAUSE = 3'd4;
`endif

    // One-hot classification of a fetched word
    typedef struct packed {
        logic jump;
        logic stop;
        logic issue;
    } fetch_class_t;

endpackage

// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
// Combinational classifier of the word read from program memory. Exactly one
// of cls.jump / cls.stop / cls.issue is set for every opcode value; all-zero
// and unknown opcodes are classified as issue (forwarded unchanged).
// Ports:
//   opcode  in  5  opcode field of the fetched word
//   operand in  8  address/immediate field of the fetched word
//   cls     out 3  {jump, stop, issue} classification
//   target  out 8  jump target (meaningful only when cls.jump)
// -----------------------------------------------------------------------------
module fetch_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [ADDR_W-1:0] operand,
    output fetch_class_t      cls,
    output logic [ADDR_W-1:0] target
);

    // Classify the opcode; default arm forwards every non-control opcode
    always_comb begin
        cls = 3'b000;
        case (opcode)
            OP_JMP:  cls.jump  = 1'b1;
            OP_STOP: cls.stop  = 1'b1;
            default: cls.issue = 1'b1;
        endcase
    end

    assign target = operand;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch and sequencing controller. Owns the program counter,
// addresses a combinational program memory, registers each fetched word and
// presents it to execute over a valid/ready handshake. JMP and STOP are
// resolved here and never reach execute.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   start          in   1   pulse; (re)starts at address 0 from IDLE/HALT
//   mem_addr       out  8   program memory address (= pc)
//   mem_data       in   16  instruction word at mem_addr, same cycle
//   instr          out  16  registered instruction for execute
//   instr_pc       out  8   address instr was fetched from
//   instr_valid    out  1   instr/instr_pc valid
//   instr_ready    in   1   execute accepts the presented instruction
//   redirect       in   1   with a handshake: next fetch from redirect_addr
//   redirect_addr  in   8   branch target
//   halted         out  1   high in HALT
//   busy           out  1   high in FETCH or ISSUE
//   step           in   1   single-step pulse (only with SEQ_STEP_EN)
//
// Optional feature macro: SEQ_STEP_EN. When defined, every accepted issue
// parks the FSM in PAUSE until a step pulse; when undefined there is no step
// port and ISSUE returns straight to FETCH.
//
// Status outputs (instr_valid, halted, busy) are registered from the next
// state so that they are glitch-free and line up with the state register.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [INSTR_W-1:0]  mem_data,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                halted,
    output logic                busy
`ifdef SEQ_STEP_EN
    ,
    input  logic                step
`endif
);

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_nxt_s;
    logic [INSTR_W-1:0]  instr_r;
    logic [ADDR_W-1:0]   instr_pc_r;
    logic                valid_r;
    logic                halted_r;
    logic                busy_r;
    logic                load_s;
    fetch_class_t        cls_s;
    logic [ADDR_W-1:0]   target_s;

    fetch_decode u_decode (
        .opcode  (mem_data[OPC_MSB:OPC_LSB]),
        .operand (mem_data[IMM_MSB:IMM_LSB]),
        .cls     (cls_s),
        .target  (target_s)
    );

    // Next-state, next-pc and instruction-load decision
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_nxt_s    = 8'h00;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FETCH: begin
                if (cls_s.jump) begin
                    // A JMP to its own address spins here until reset.
                    pc_nxt_s    = target_s;
                    state_nxt_s = ST_FETCH;
                end else if (cls_s.stop) begin
                    // pc keeps pointing at the STOP word
                    state_nxt_s = ST_HALT;
                end else if (cls_s.issue) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    if (redirect) begin
                        pc_nxt_s = redirect_addr;
                    end else begin
                        // 8-bit add wraps 8'hFF to 8'h00
                        pc_nxt_s = pc_r + 8'd1;
                    end
`ifdef SEQ_STEP_EN
                    state_nxt_s = ST_PAUSE;
`else
                    state_nxt_s = ST_FETCH;
`endif
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
`ifdef SEQ_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Instruction register: loaded only on a FETCH that issues, so it stays
    // stable for the whole ISSUE stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r    <= 16'h0000;
            instr_pc_r <= 8'h00;
        end else if (load_s) begin
            instr_r    <= mem_data;
            instr_pc_r <= pc_r;
        end else begin
            instr_r    <= instr_r;
            instr_pc_r <= instr_pc_r;
        end
    end

    // Registered status flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            valid_r  <= (state_nxt_s == ST_ISSUE);
            halted_r <= (state_nxt_s == ST_HALT);
            busy_r   <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_ISSUE);
        end
    end

    assign mem_addr    = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = valid_r;
    assign halted      = halted_r;
    assign busy        = busy_r;

endmodule
